// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared types and limits for the data-memory responder
package data_mem_pkg;

  localparam int unsigned MAX_GNT_DELAY   = 15;
  localparam int unsigned MAX_RSP_LATENCY = 8;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } mem_rsp_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } gnt_state_e;

endpackage

// File: rtl/data_mem_resp_if.sv
// rtl/data_mem_resp_if.sv - core load/store request/grant/rvalid bus
interface data_mem_resp_if;

  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        data_err_i;

  modport master (
    output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
  );

  modport slave (
    input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i
  );

endinterface

// File: rtl/data_mem_rsp_pipe.sv
// rtl/data_mem_rsp_pipe.sv - fixed-latency delay line of memory responses
module data_mem_rsp_pipe
  import data_mem_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic     clk,
  input  logic     rst_ni,
  input  mem_rsp_t rsp_in,
  output mem_rsp_t rsp_out
);

  mem_rsp_t stage_q [LATENCY];

  // Clearing every stage on reset drops all in-flight responses at once.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(LATENCY); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= rsp_in;
      for (int i = 1; i < int'(LATENCY); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign rsp_out = stage_q[LATENCY-1];

endmodule

// File: rtl/data_mem_resp.sv
// rtl/data_mem_resp.sv - SRAM-backed responder for the core data port; DATA_MEM_ERR_EN enables out-of-range errors
module data_mem_resp
  import data_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned SIZE_BYTES  = 65536,
  parameter int unsigned GNT_DELAY   = 0,
  parameter int unsigned RSP_LATENCY = 1
) (
  input logic            clk,
  input logic            rst_ni,
  data_mem_resp_if.slave mem
);

  localparam int unsigned DEPTH = SIZE_BYTES / 4;
  localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  gnt_state_e  state_q;
  logic [3:0]  cnt_q;
  logic        armed_q;
  logic        gnt;
  logic        acc;
  logic        acc_ok;
  logic [31:0] offset;
  logic [29:0] word_idx;
  logic [IW-1:0] arr_idx;
  logic [31:0] mem_q [DEPTH];
  mem_rsp_t    rsp_in;
  mem_rsp_t    rsp_out;
  logic        unused_bits;

  // armed_q mirrors (WAIT && cnt == 0) so the grant comes from a flop gated only by req.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem.data_req_o && GNT_DELAY != 0) begin
            state_q <= WAIT;
            cnt_q   <= 4'(GNT_DELAY - 1);
            armed_q <= (GNT_DELAY == 1);
          end
        end
        WAIT: begin
          if (!mem.data_req_o || cnt_q == 4'd0) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            armed_q <= 1'b0;
          end else begin
            cnt_q   <= cnt_q - 4'd1;
            armed_q <= (cnt_q == 4'd1);
          end
        end
      endcase
    end
  end

  assign gnt = (GNT_DELAY == 0) ? mem.data_req_o : (armed_q & mem.data_req_o);
  assign acc = mem.data_req_o & gnt;

  assign offset   = mem.data_addr_o - BASE_ADDR;
  assign word_idx = offset[31:2];

  generate
    if (DEPTH > 1) begin : g_idx
      assign arr_idx = word_idx[IW-1:0];
    end else begin : g_idx_one
      assign arr_idx = '0;
    end
  endgenerate

`ifdef DATA_MEM_ERR_EN
  assign acc_ok = ({2'b00, word_idx} < 32'(DEPTH));
`else
  assign acc_ok = 1'b1;
`endif

  assign unused_bits = ^{offset[1:0], word_idx};

  // The array is deliberately left unreset; contents survive rst_ni.
  always_ff @(posedge clk) begin
    if (acc && mem.data_we_o && acc_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (mem.data_be_o[b]) begin
          mem_q[arr_idx][8*b +: 8] <= mem.data_wdata_o[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rsp_in       = '0;
    rsp_in.valid = acc;
    rsp_in.err   = acc & ~acc_ok;
    if (acc && !mem.data_we_o && acc_ok) begin
      rsp_in.rdata = mem_q[arr_idx];
    end
  end

  data_mem_rsp_pipe #(
    .LATENCY (RSP_LATENCY)
  ) u_rsp_pipe (
    .clk     (clk),
    .rst_ni  (rst_ni),
    .rsp_in  (rsp_in),
    .rsp_out (rsp_out)
  );

  assign mem.data_gnt_i    = gnt;
  assign mem.data_rvalid_i = rsp_out.valid;
  assign mem.data_rdata_i  = rsp_out.rdata;
  assign mem.data_err_i    = rsp_out.err;

endmodule

// File: tb/tb_data_mem_resp.sv
// tb/tb_data_mem_resp.sv - randomized and directed checks of three data_mem_resp configurations
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_resp_if bus_a ();
  data_mem_resp_if bus_b ();
  data_mem_resp_if bus_c ();

  assign bus_a.data_req_o = req;   assign bus_b.data_req_o = req;   assign bus_c.data_req_o = req;
  assign bus_a.data_we_o = we;     assign bus_b.data_we_o = we;     assign bus_c.data_we_o = we;
  assign bus_a.data_be_o = be;     assign bus_b.data_be_o = be;     assign bus_c.data_be_o = be;
  assign bus_a.data_addr_o = addr; assign bus_b.data_addr_o = addr; assign bus_c.data_addr_o = addr;
  assign bus_a.data_wdata_o = wdata; assign bus_b.data_wdata_o = wdata; assign bus_c.data_wdata_o = wdata;

  logic [2:0]  gnt_s, rv_s, err_s;
  logic [31:0] rd_s [3];
  assign gnt_s = {bus_c.data_gnt_i, bus_b.data_gnt_i, bus_a.data_gnt_i};
  assign rv_s  = {bus_c.data_rvalid_i, bus_b.data_rvalid_i, bus_a.data_rvalid_i};
  assign err_s = {bus_c.data_err_i, bus_b.data_err_i, bus_a.data_err_i};
  assign rd_s[0] = bus_a.data_rdata_i;
  assign rd_s[1] = bus_b.data_rdata_i;
  assign rd_s[2] = bus_c.data_rdata_i;

  data_mem_resp #(.BASE_ADDR(32'h0000_0000), .SIZE_BYTES(65536), .GNT_DELAY(0), .RSP_LATENCY(1))
    u_a (.clk(clk), .rst_ni(rst_n), .mem(bus_a));
  data_mem_resp #(.BASE_ADDR(32'h0000_0000), .SIZE_BYTES(256), .GNT_DELAY(0), .RSP_LATENCY(4))
    u_b (.clk(clk), .rst_ni(rst_n), .mem(bus_b));
  data_mem_resp #(.BASE_ADDR(32'h0000_1000), .SIZE_BYTES(1024), .GNT_DELAY(3), .RSP_LATENCY(2))
    u_c (.clk(clk), .rst_ni(rst_n), .mem(bus_c));

  function automatic int gd(input int k);
    return (k == 2) ? 3 : 0;
  endfunction
  function automatic int lat(input int k);
    return (k == 0) ? 1 : (k == 1) ? 4 : 2;
  endfunction
  function automatic logic [31:0] base(input int k);
    return (k == 2) ? 32'h1000 : 32'h0;
  endfunction
  function automatic longint size_b(input int k);
    return (k == 0) ? 65536 : (k == 1) ? 256 : 1024;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t actual=%h required=%h", nm, k, $time, act, exp);
    end
  endtask

  // Reference memory: byte contents plus which bytes have ever been written.
  typedef struct {
    int          k;
    int          due;
    logic        err;
    logic [31:0] d;
    logic [31:0] m;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mdat [longint];
  logic [3:0]  mknown [longint];
  int          run [3];

  function automatic void map_addr(input int k, input logic [31:0] a, output logic ok, output longint key);
    logic [31:0]     off;
    longint unsigned wi;
    off = a - base(k);
    wi  = longint'(off) / 4;
`ifdef DATA_MEM_ERR_EN
    ok = (wi < size_b(k) / 4);
`else
    ok = 1'b1;
    wi = wi % (size_b(k) / 4);
`endif
    key = (longint'(k) << 32) + longint'(wi);
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        chk("reset_gnt", k, gnt_s[k], 0);
        chk("reset_rvalid", k, rv_s[k], 0);
        chk("reset_rdata", k, rd_s[k], 0);
        chk("reset_err", k, err_s[k], 0);
        run[k] = 0;
      end
      q.delete();
    end else begin
      for (int k = 0; k < 3; k++) begin
        logic        eg, ok;
        int          hi;
        longint      key;
        exp_t        e;
        logic [31:0] w;
        logic [3:0]  kn;
        eg = req && (run[k] == gd(k));
        chk("gnt", k, gnt_s[k], eg);
        hi = -1;
        for (int i = 0; i < q.size(); i++) begin
          if (q[i].k == k) begin
            hi = i;
            break;
          end
        end
        if (hi >= 0 && q[hi].due == cyc) begin
          chk("rvalid", k, rv_s[k], 1);
          chk("err", k, err_s[k], q[hi].err);
          chk("rdata", k, rd_s[k] & q[hi].m, q[hi].d & q[hi].m);
          q.delete(hi);
        end else begin
          chk("idle_rvalid", k, rv_s[k], 0);
          chk("idle_rdata", k, rd_s[k], 0);
          chk("idle_err", k, err_s[k], 0);
        end
        if (eg) begin
          map_addr(k, addr, ok, key);
          e.k   = k;
          e.due = cyc + lat(k);
          e.err = !ok;
          e.d   = 32'h0;
          e.m   = 32'hFFFF_FFFF;
          if (ok) begin
            if (!mdat.exists(key)) begin
              mdat[key]   = 32'h0;
              mknown[key] = 4'h0;
            end
            w  = mdat[key];
            kn = mknown[key];
            if (we) begin
              for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                  w[8*b +: 8] = wdata[8*b +: 8];
                  kn[b] = 1'b1;
                end
              end
              mdat[key]   = w;
              mknown[key] = kn;
            end else begin
              e.d = w;
              for (int b = 0; b < 4; b++) e.m[8*b +: 8] = {8{kn[b]}};
            end
          end
          q.push_back(e);
        end
        run[k] = (!req || eg) ? 0 : run[k] + 1;
      end
    end
  end

  task automatic drv(input logic r, input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    req = r; we = w; be = b; addr = a; wdata = d;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 'h3FF));
      1:       return 32'h1000 + 32'($urandom_range(0, 'h7FF));
      2:       return $urandom;
      default: return 32'h0001_0000 + 32'($urandom_range(0, 'hFF));
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("por_rvalid", 0, 32'(rv_s), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle();

    // Store then immediate load on the zero-delay, single-latency instance.
    drv(1, 1, 4'hF, 32'h100, 32'hDEAD_BEEF);
    @(negedge clk); chk("t1_gnt", 0, gnt_s[0], 1);
    drv(1, 0, 4'hF, 32'h100, 32'h0);
    @(negedge clk); chk("t1_store_rvalid", 0, rv_s[0], 1); chk("t1_store_rdata", 0, rd_s[0], 0);
    idle();
    @(negedge clk); chk("t1_load_rvalid", 0, rv_s[0], 1); chk("t1_load_rdata", 0, rd_s[0], 32'hDEAD_BEEF);
    chk("t1_load_err", 0, err_s[0], 0);

    drv(1, 1, 4'hF, 32'h104, 32'h1122_3344);
    drv(1, 1, 4'b0101, 32'h104, 32'hAABB_CCDD);
    drv(1, 0, 4'h0, 32'h104, 32'h0);
    idle();
    @(negedge clk); chk("t2_be_merge", 0, rd_s[0], 32'h11BB_33DD);
    idle(); idle();

    // Delayed-grant instance: held req grants only in cycle 3.
    for (int i = 0; i < 4; i++) begin
      drv(1, 0, 4'hF, 32'h1008, 32'h0);
      @(negedge clk); chk("t3_gnt_hold", 2, gnt_s[2], (i == 3));
    end
    idle(); @(negedge clk); chk("t3_rvalid_early", 2, rv_s[2], 0);
    idle(); @(negedge clk); chk("t3_rvalid", 2, rv_s[2], 1);
    idle(); idle();
    for (int i = 0; i < 7; i++) begin
      if (i < 2) drv(1, 0, 4'hF, 32'h1008, 32'h0);
      else       idle();
      @(negedge clk);
      chk("t3_drop_gnt", 2, gnt_s[2], 0);
      chk("t3_drop_rvalid", 2, rv_s[2], 0);
    end

    // Eight back-to-back loads through the four-stage pipeline.
    for (int i = 0; i < 8; i++) drv(1, 1, 4'hF, 32'(4 * i), 32'hA500_0000 + 32'(i));
    for (int j = 0; j < 13; j++) begin
      if (j < 8) drv(1, 0, 4'hF, 32'(4 * j), 32'h0);
      else       idle();
      @(negedge clk);
      chk("t4_rvalid", 1, rv_s[1], (j < 12));
      chk("t4_rdata", 1, rd_s[1], (j >= 4 && j < 12) ? 32'hA500_0000 + 32'(j - 4) : 32'h0);
    end

    drv(1, 1, 4'hF, 32'h0, 32'h1234_5678);
    drv(1, 0, 4'hF, 32'h0001_0000, 32'h0);
    drv(1, 1, 4'hF, 32'h0001_0000, 32'h5555_5555);
    @(negedge clk);
`ifdef DATA_MEM_ERR_EN
    chk("t5_oor_err", 0, err_s[0], 1); chk("t5_oor_rdata", 0, rd_s[0], 0);
`else
    chk("t5_wrap_err", 0, err_s[0], 0); chk("t5_wrap_rdata", 0, rd_s[0], 32'h1234_5678);
`endif
    drv(1, 0, 4'hF, 32'h0, 32'h0);
    idle();
    @(negedge clk);
`ifdef DATA_MEM_ERR_EN
    chk("t5_word0", 0, rd_s[0], 32'h1234_5678);
`else
    chk("t5_word0", 0, rd_s[0], 32'h5555_5555);
`endif
    repeat (6) idle();

    // Reset with three loads in flight in the four-stage instance.
    drv(1, 0, 4'hF, 32'h0, 32'h0);
    drv(1, 0, 4'hF, 32'h4, 32'h0);
    drv(1, 0, 4'hF, 32'h8, 32'h0);
    @(posedge clk);
    #1 req = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idle();
      @(negedge clk); chk("t6_no_rvalid", 0, 32'(rv_s), 0);
    end
    drv(1, 0, 4'hF, 32'h4, 32'h0);
    @(negedge clk);
    idle(); @(negedge clk); chk("t6_keep_a", 0, rd_s[0], 32'hA500_0001);
    repeat (3) idle();
    @(negedge clk); chk("t6_keep_b", 1, rd_s[1], 32'hA500_0001);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        @(posedge clk);
        #1 req = 1'b0; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
      end else begin
        drv(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            rand_addr(), $urandom);
      end
    end
    repeat (10) idle();
    @(negedge clk);
    chk("drained", 0, 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Synthesizable data-memory responder for the core's load/store port. It sits directly downstream of the core's data interface and consumes `data_req_o`, `data_we_o`, `data_be_o`, `data_addr_o` and `data_wdata_o`. It produces `data_gnt_i`, `data_rvalid_i`, `data_rdata_i` and `data_err_i` with a programmable grant delay and a fixed response latency. It backs the request/grant/rvalid protocol with a word-addressed SRAM array, so the UVM environment can run against a real memory.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: first byte address mapped.
- `SIZE_BYTES`, default 65536: mapped bytes; a power of two, at least 4.
- `GNT_DELAY`, default 0: cycles `data_req_o` must be held high before `data_gnt_i` is asserted; range 0..15.
- `RSP_LATENCY`, default 1: cycles from acceptance to `data_rvalid_i`; range 1..8.
- `clk` in 1: single clock, rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `data_req_o` in 1: request valid.
- `data_we_o` in 1: 1 = store, 0 = load.
- `data_be_o` in 4: byte enables.
- `data_addr_o` in 32: byte address; bits [1:0] are ignored.
- `data_wdata_o` in 32: store data.
- `data_gnt_i` out 1: request accepted this cycle.
- `data_rvalid_i` out 1: response valid, exactly one cycle per accepted request.
- `data_rdata_i` out 32: load data; 0 for stores and errors.
- `data_err_i` out 1: error response; qualified by `data_rvalid_i`.

## Operation
- A request is accepted in cycle T when `data_req_o` and `data_gnt_i` are both high in T.
- Grant FSM has two states, IDLE and WAIT, with a 4-bit counter `cnt`.
  - `GNT_DELAY` = 0: `data_gnt_i` = `data_req_o`, combinational; the FSM stays in IDLE.
  - IDLE: if `req`, load `cnt` = `GNT_DELAY` - 1 and go to WAIT. `gnt` stays 0.
  - WAIT: if `cnt` == 0, drive `gnt` = `req`, return to IDLE, and accept the request.
  - WAIT: otherwise decrement `cnt`.
  - `req` dropping in WAIT returns the FSM to IDLE with no grant.
- Word index = (`addr` - `BASE_ADDR`) >> 2. The subtraction is 32-bit and wraps.
- Store on acceptance: write the bytes whose `be` bit is set at the end of cycle T. A response with `rdata` = 0 follows.
- Load on acceptance: read the array word in cycle T, including any write completed in earlier cycles. The read data enters the response pipeline.
- A load with `be` = 0 still returns the full word. A store with `be` = 0 writes nothing.
- Response pipeline: an `RSP_LATENCY`-stage shift register carrying {valid, err, rdata}.
  - Responses leave in order.
  - Back-to-back accepts give back-to-back rvalids.
  - There is no backpressure from the core.
- The SRAM array is not reset. Its contents are undefined after power-up until written.

## Timing
- Reset values: `data_gnt_i` = 0, `data_rvalid_i` = 0, `data_rdata_i` = 0, `data_err_i` = 0. The FSM is in IDLE, `cnt` = 0 and all pipeline stages are invalid.
- Grant is asserted `GNT_DELAY` cycles after `req` first rises, under continuous `req`.
- `data_rvalid_i` is high in cycle T + `RSP_LATENCY`. `rdata` and `err` are valid only in that cycle and are 0 otherwise.
- A store accepted in T followed by a load to the same word accepted in T+1 returns the new data.
- Reset asserted mid-operation clears all in-flight responses at once; none are delivered after release. Array contents are preserved.
- There is at most one acceptance per cycle. Up to `RSP_LATENCY` responses can be outstanding.

## Configuration
- `DATA_MEM_ERR_EN` defined:
  - An access with index ≥ `SIZE_BYTES`/4 responds with `err` = 1 and `rdata` = 0.
  - An out-of-range store does not write.
- `DATA_MEM_ERR_EN` undefined:
  - The index wraps modulo `SIZE_BYTES`/4.
  - `data_err_i` is tied to 0.

## Structure
- Package `data_mem_pkg`:
  - typedef `mem_rsp_t` = {valid, err, rdata[31:0]}.
  - enum `gnt_state_e` = {IDLE, WAIT}.
  - constants `MAX_GNT_DELAY` = 15 and `MAX_RSP_LATENCY` = 8.
- One sub-module, `data_mem_rsp_pipe`: the parameterized delay line of `mem_rsp_t`.
- The grant FSM and the array stay in the top module.

## Test plan
- Reset, `GNT_DELAY` = 0, `RSP_LATENCY` = 1: store 32'hDEADBEEF at 32'h100 with `be` = 4'hF, then load 32'h100 the next cycle. Required: rvalid at T+1 with rdata 0, then rvalid at T+2 with rdata 32'hDEADBEEF and err 0.
- Byte enables: word 0x104 holds 32'h11223344; store 32'hAABBCCDD with `be` = 4'b0101, then load. Required: rdata 32'h11BB33DD.
- `GNT_DELAY` = 3, `req` held from cycle 0. Required: gnt high only in cycle 3, rvalid in cycle 3 + `RSP_LATENCY`. Dropping `req` in cycle 2 gives no gnt and no rvalid.
- `RSP_LATENCY` = 4, eight back-to-back loads to 0x0..0x1C. Required: eight consecutive rvalids starting 4 cycles after the first accept, in address order.
- With `DATA_MEM_ERR_EN`, `SIZE_BYTES` = 65536: load 32'h0001_0000. Required: rvalid with err 1 and rdata 0. A store to the same address leaves word 0 unchanged.
- Assert `rst_ni` low while 3 responses are in flight, then release. Required: rvalid stays 0 until a new accept, and data written before reset reads back intact.
